// File: rtl/counter_pkg.sv
// Shared definitions for the prescaled modulo counter.
//   DIR_UP / DIR_DOWN : encodings of the up_dn direction input
//   clog2()           : ceiling log2, for deriving register widths from ranges
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles and flags the cycle on which the counter steps.
//   clk     : system clock, rising edge
//   clear_n : asynchronous active-low reset
//   en      : enable; 0 freezes the prescaler
//   restart : restart the period from zero (sync clear or load in the parent)
//   step    : combinational, high when the current enabled cycle ends a period
module tick_gen #(
  parameter int unsigned DIV_WIDTH    = 27,
  parameter int unsigned DIV_TERMINAL = 134217727
) (
  input  logic clk,
  input  logic clear_n,
  input  logic en,
  input  logic restart,
  output logic step
);

  localparam logic [DIV_WIDTH-1:0] DivTerm = DIV_WIDTH'(DIV_TERMINAL);

  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic                 at_term;

  assign at_term = (div_cnt_q == DivTerm);
  assign step    = en & at_term;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (restart) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = at_term ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/mod_counter_prescaled.sv
// Up/down modulo counter stepped by a configurable prescaler.
//   clk      : system clock, rising edge
//   clear_n  : asynchronous active-low reset
//   en       : count enable; 0 freezes prescaler and counter
//   up_dn    : direction, 1 = up, 0 = down (sampled at step edges)
//   sync_clr : synchronous clear, highest priority
//   load     : synchronous parallel load, saturated to MODULUS-1
//   load_val : value to load
//   count    : registered count, 0..MODULUS-1
//   tick     : registered pulse in each cycle the counter stepped
//   wrap     : registered pulse in the cycle the counter wrapped
//   tc       : combinational terminal count for the current direction
module mod_counter_prescaled
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned MODULUS      = 16,
  parameter int unsigned DIV_WIDTH    = 27,
  parameter int unsigned DIV_TERMINAL = 134217727
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sync_clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap,
  output logic             tc
);

  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   ModWide = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MaxCnt  = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             step;
  logic             at_max;
  logic             at_zero;

  tick_gen #(
    .DIV_WIDTH   (DIV_WIDTH),
    .DIV_TERMINAL(DIV_TERMINAL)
  ) u_tick_gen (
    .clk    (clk),
    .clear_n(clear_n),
    .en     (en),
    .restart(sync_clr | load),
    .step   (step)
  );

  assign at_max  = (count_q == MaxCnt);
  assign at_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (sync_clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = ({1'b0, load_val} < ModWide) ? load_val : MaxCnt;
    end else if (step) begin
      tick_d = 1'b1;
      if (up_dn == DIR_UP) begin
        if (at_max) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          count_d = MaxCnt;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;
  assign tc    = ((up_dn == DIR_UP) & at_max) | ((up_dn == DIR_DOWN) & at_zero);

endmodule

// File: tb/tb_mod_counter_prescaled.sv
module tb_mod_counter_prescaled;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       en;
  logic       up_dn;
  logic       sync_clr;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tick;
  logic       wrap;
  logic       tc;

  int vectors = 0;
  int errs    = 0;

  mod_counter_prescaled #(
    .WIDTH       (4),
    .MODULUS     (10),
    .DIV_WIDTH   (4),
    .DIV_TERMINAL(3)
  ) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .en      (en),
    .up_dn   (up_dn),
    .sync_clr(sync_clr),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .tick    (tick),
    .wrap    (wrap),
    .tc      (tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Three non-stepping edges then the step edge; sampled on falling edges.
  task automatic wait_step();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_step_tick", 32'(tick), 0);
    chk("pre_step_wrap", 32'(wrap), 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single-edge load, sampled on the following falling edge.
  task automatic do_load(input logic [3:0] v);
    load     = 1'b1;
    load_val = v;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    clear_n  = 1'b0;
    en       = 1'b1;
    up_dn    = 1'b1;
    sync_clr = 1'b0;
    load     = 1'b0;
    load_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_tc", 32'(tc), 0);
    clear_n = 1'b1;

    // Up-count: ten steps, 1..9 then wrap to 0.
    for (int k = 1; k <= 10; k++) begin
      wait_step();
      chk("up_count", 32'(count), 32'(k % 10));
      chk("up_tick", 32'(tick), 1);
      chk("up_wrap", 32'(wrap), (k == 10) ? 1 : 0);
      chk("up_tc", 32'(tc), (k == 9) ? 1 : 0);
    end

    // Down-count from 0: wraps to 9, then 8, 7.
    up_dn = 1'b0;
    #1;
    chk("dn_tc_at0", 32'(tc), 1);
    wait_step();
    chk("dn_wrap_count", 32'(count), 9);
    chk("dn_wrap_flag", 32'(wrap), 1);
    chk("dn_wrap_tc", 32'(tc), 0);
    wait_step();
    chk("dn_count8", 32'(count), 8);
    chk("dn_wrap8", 32'(wrap), 0);
    wait_step();
    chk("dn_count7", 32'(count), 7);

    // Load coincident with a step edge: step discarded, period restarts.
    up_dn = 1'b1;
    do_load(4'd3);
    chk("ld_count3", 32'(count), 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ld_pre_count", 32'(count), 3);
    do_load(4'd7);
    chk("ld_step_count", 32'(count), 7);
    chk("ld_step_tick", 32'(tick), 0);
    wait_step();
    chk("ld_next_count", 32'(count), 8);
    chk("ld_next_tick", 32'(tick), 1);

    // Saturating load, then load honoured with en=0, then hold.
    do_load(4'd12);
    chk("sat_count", 32'(count), 9);
    chk("sat_tc", 32'(tc), 1);
    en = 1'b0;
    do_load(4'd5);
    chk("ld_en0_count", 32'(count), 5);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_count", 32'(count), 5);
      chk("hold_tick", 32'(tick), 0);
    end

    // sync_clr beats load; period restarts from zero.
    do_load(4'd4);
    chk("pri_pre_count", 32'(count), 4);
    en       = 1'b1;
    sync_clr = 1'b1;
    do_load(4'd6);
    sync_clr = 1'b0;
    chk("pri_count", 32'(count), 0);
    chk("pri_tick", 32'(tick), 0);
    wait_step();
    chk("pri_next_count", 32'(count), 1);

    // Asynchronous reset between edges, then hold with en=0.
    do_load(4'd6);
    chk("ar_pre_count", 32'(count), 6);
    #2;
    clear_n = 1'b0;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_tick", 32'(tick), 0);
    chk("ar_wrap", 32'(wrap), 0);
    en = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("ar_hold_count", 32'(count), 0);
      chk("ar_hold_tick", 32'(tick), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
